systolic_pe: RTL and testbench
==============================

Name: systolic_pe

Overview:
Parametrised processing element for the weight/image systolic array of the MNIST accelerator. Each element multiplies a weight by an image operand and accumulates the product over a programmed number of valid samples. It supports signed or unsigned operands and optional saturation with a sticky overflow flag. Weight and image operands are forwarded through registers to the east and south neighbours, so a grid of these elements forms the array.

Parameters:
DW, 8, operand width of w_in/im_in (bits)
AW, 32, accumulator/result width; 2*DW <= AW is required
SIGNED, 1, 1 = two's-complement operands and accumulator; 0 = unsigned
SAT, 1, 1 = clamp on overflow; 0 = wrap modulo 2^AW
CW, 10, width of the accumulation-length counter

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
start  input  1  clear accumulator, load len, begin a new accumulation
len  input  CW  number of valid samples to accumulate, sampled when start=1
in_valid  input  1  w_in/im_in carry a valid sample this cycle
w_in  input  DW  weight operand from west neighbour
im_in  input  DW  image operand from north neighbour
w_out  output  DW  registered copy of w_in, to east neighbour
im_out  output  DW  registered copy of im_in, to south neighbour
out_valid  output  1  registered copy of in_valid
p  output  AW  accumulator value
busy  output  1  high in ACC state
done  output  1  high in DONE state; p is final
ovf  output  1  sticky overflow flag for the current accumulation

Behaviour:
- Reset (clk edge with rst=1): state=IDLE; p, cnt, ovf, w_out, im_out and out_valid are all 0; busy=0; done=0. rst overrides start and in_valid. A reset during an accumulation discards it.
- Forwarding: w_out<=w_in, im_out<=im_in, out_valid<=in_valid on every edge, in all states, independent of start. Latency is exactly 1 cycle.
- States: IDLE, ACC, DONE. busy=(state==ACC) and done=(state==DONE), both decoded from state (no extra delay).
- start=1 in any state: p<=0, ovf<=0, cnt<=len.
  - If len==0, go to DONE; otherwise go to ACC.
  - A sample presented in the same cycle as start is forwarded but not accumulated.
- ACC with in_valid=1:
  - p<=f(p + prod) and cnt<=cnt-1.
  - If cnt==1, go to DONE. Done rises on the edge that accumulates the last sample, so p is final in the same cycle done=1.
- ACC with in_valid=0: hold p and cnt (bubbles allowed).
- IDLE and DONE: in_valid is ignored for accumulation; p holds. DONE persists until start or rst.
- Product:
  - SIGNED=1: prod = signed(w_in)*signed(im_in), 2*DW bits, sign-extended to AW.
  - SIGNED=0: unsigned product, zero-extended to AW.
- Sum is computed at AW+1 bits.
  - Signed overflow: both addends share a sign and the result sign differs.
  - Unsigned overflow: carry out of bit AW-1.
- On overflow, ovf<=1 (sticky until start/rst).
  - SAT=1: p clamps to max (signed 2^(AW-1)-1, unsigned 2^AW-1) or, for signed negative overflow, to min -2^(AW-1).
  - SAT=0: p keeps the low AW bits.
- Once saturated, later samples continue to accumulate from the clamped value.
- start and last-sample in the same cycle: start wins; the sample is not counted.

Test Plan:
1. DW=8, AW=32, SIGNED=1, SAT=1. Sequence: rst, start len=3, then samples (2,3), (-4,5), (7,-1) on consecutive cycles -> p=-21 (0xFFFFFFEB), done=1 and busy=0 the cycle after the 3rd sample edge, ovf=0.
2. Forwarding: w_in=0x5A, im_in=0xA5, in_valid=1 at edge n, while in IDLE, ACC and DONE -> w_out=0x5A, im_out=0xA5, out_valid=1 after edge n. After rst, all forwarded outputs are 0.
3. Overflow, AW=16, DW=8, signed, len=3, three samples (127,127):
   - SAT=1 -> p=0x7FFF, ovf=1.
   - SAT=0 -> p=0xBD03 (-17149), ovf=1.
   - A following start clears ovf and p.
4. Bubbles: len=2, in_valid pattern 1,0,0,1 with samples (3,4), x, x, (5,6) -> p=42. busy stays high across the bubbles; done rises only after the 4th cycle's edge.
5. Edge cases:
   - start with len=0 -> DONE next cycle, p=0.
   - start with in_valid=1 and sample (9,9) -> sample is not accumulated (p=0), out_valid=1.
   - start asserted while in ACC mid-count -> restarts with the new len.
6. rst asserted after 1 of 3 samples -> state IDLE, p=0, ovf=0, busy=0, done=0. Later in_valid samples are ignored until start.

Source files
------------

// File: rtl/systolic_pe.sv
// rtl/systolic_pe.sv - multiply-accumulate processing element for the weight/image systolic array
//
// Multiplies the west weight operand by the north image operand and accumulates
// the product over a programmed number of valid samples. Operands are forwarded
// east/south through one register stage so a grid of these elements forms the array.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   start      clear accumulator and overflow, load len, begin a new accumulation
//   len        number of valid samples to accumulate, sampled with start
//   in_valid   w_in/im_in carry a valid sample
//   w_in       weight operand from west neighbour
//   im_in      image operand from north neighbour
//   w_out      registered w_in, to east neighbour
//   im_out     registered im_in, to south neighbour
//   out_valid  registered in_valid
//   p          accumulator value
//   busy       accumulation in progress
//   done       accumulation complete, p is final
//   ovf        sticky overflow flag for the current accumulation

module systolic_pe #(
   parameter int DW     = 8,
   parameter int AW     = 32,
   parameter int SIGNED = 1,
   parameter int SAT    = 1,
   parameter int CW     = 10
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [CW-1:0] len,
   input  logic          in_valid,
   input  logic [DW-1:0] w_in,
   input  logic [DW-1:0] im_in,
   output logic [DW-1:0] w_out,
   output logic [DW-1:0] im_out,
   output logic          out_valid,
   output logic [AW-1:0] p,
   output logic          busy,
   output logic          done,
   output logic          ovf
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ACC  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t        r_state;
   logic [AW-1:0] r_p;
   logic [CW-1:0] r_cnt;
   logic          r_ovf;
   logic [DW-1:0] r_w_out;
   logic [DW-1:0] r_im_out;
   logic          r_out_valid;

   logic [2*DW-1:0] w_prod_raw;
   logic [AW-1:0]   w_prod;
   logic [AW:0]     w_sum;
   logic            w_ovf;
   logic [AW-1:0]   w_next;

   always_comb begin
      w_prod_raw = '0;
      w_prod     = '0;
      if (SIGNED != 0) begin
         // Operands are widened to the product width first so the multiply is exact.
         w_prod_raw = $signed({{DW{w_in[DW-1]}}, w_in}) * $signed({{DW{im_in[DW-1]}}, im_in});
         w_prod     = AW'($signed(w_prod_raw));
      end else begin
         w_prod_raw = {{DW{1'b0}}, w_in} * {{DW{1'b0}}, im_in};
         w_prod     = AW'(w_prod_raw);
      end

      w_sum = {1'b0, r_p} + {1'b0, w_prod};

      if (SIGNED != 0)
         w_ovf = (r_p[AW-1] == w_prod[AW-1]) && (w_sum[AW-1] != r_p[AW-1]);
      else
         w_ovf = w_sum[AW];

      w_next = w_sum[AW-1:0];
      if (w_ovf && (SAT != 0)) begin
         if (SIGNED == 0)
            w_next = '1;
         else if (r_p[AW-1])
            w_next = {1'b1, {(AW-1){1'b0}}};
         else
            w_next = {1'b0, {(AW-1){1'b1}}};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_p         <= '0;
         r_cnt       <= '0;
         r_ovf       <= 1'b0;
         r_w_out     <= '0;
         r_im_out    <= '0;
         r_out_valid <= 1'b0;
      end else begin
         r_w_out     <= w_in;
         r_im_out    <= im_in;
         r_out_valid <= in_valid;

         // start takes priority over any sample presented in the same cycle.
         if (start) begin
            r_p   <= '0;
            r_ovf <= 1'b0;
            r_cnt <= len;
            r_state <= (len == '0) ? S_DONE : S_ACC;
         end else if ((r_state == S_ACC) && in_valid) begin
            r_p   <= w_next;
            r_cnt <= r_cnt - 1'b1;
            if (w_ovf)
               r_ovf <= 1'b1;
            if (r_cnt == CW'(1))
               r_state <= S_DONE;
         end
      end
   end

   assign w_out     = r_w_out;
   assign im_out    = r_im_out;
   assign out_valid = r_out_valid;
   assign p         = r_p;
   assign ovf       = r_ovf;
   assign busy      = (r_state == S_ACC);
   assign done      = (r_state == S_DONE);

endmodule

// File: tb/tb_systolic_pe.sv
// tb/tb_systolic_pe.sv - directed scoreboard bench for systolic_pe

module tb_systolic_pe;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [9:0] len;
   logic       in_valid;
   logic [7:0] w_in;
   logic [7:0] im_in;

   logic [7:0]  w_out0, im_out0, w_out1, im_out1, w_out2, im_out2;
   logic        ov0, ov1, ov2;
   logic [31:0] p0;
   logic [15:0] p1, p2;
   logic        busy0, done0, ovf0, busy1, done1, ovf1, busy2, done2, ovf2;

   always #5 clk = ~clk;

   systolic_pe #(.DW(8), .AW(32), .SIGNED(1), .SAT(1), .CW(10)) u0 (
      .clk(clk), .rst(rst), .start(start), .len(len), .in_valid(in_valid),
      .w_in(w_in), .im_in(im_in), .w_out(w_out0), .im_out(im_out0),
      .out_valid(ov0), .p(p0), .busy(busy0), .done(done0), .ovf(ovf0));

   systolic_pe #(.DW(8), .AW(16), .SIGNED(1), .SAT(1), .CW(10)) u1 (
      .clk(clk), .rst(rst), .start(start), .len(len), .in_valid(in_valid),
      .w_in(w_in), .im_in(im_in), .w_out(w_out1), .im_out(im_out1),
      .out_valid(ov1), .p(p1), .busy(busy1), .done(done1), .ovf(ovf1));

   systolic_pe #(.DW(8), .AW(16), .SIGNED(1), .SAT(0), .CW(10)) u2 (
      .clk(clk), .rst(rst), .start(start), .len(len), .in_valid(in_valid),
      .w_in(w_in), .im_in(im_in), .w_out(w_out2), .im_out(im_out2),
      .out_valid(ov2), .p(p2), .busy(busy2), .done(done2), .ovf(ovf2));

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;

   exp_t fwd_q[$];
   exp_t res_q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic push_res(input string tag, input logic [31:0] v);
      exp_t e;
      e.tag = tag;
      e.val = v;
      res_q.push_back(e);
   endtask

   task automatic pop_res(input logic [31:0] obs);
      exp_t e;
      if (res_q.size() == 0) begin
         chk("res_queue_empty", 32'd1, 32'd0);
      end else begin
         e = res_q.pop_front();
         chk(e.tag, obs, e.val);
      end
   endtask

   // One clock: the expected forwarded bundle is queued from the driven inputs
   // and compared against all three elements once the edge has passed.
   task automatic tick();
      exp_t e;
      e.tag = "fwd";
      e.val = rst ? 32'd0 : {15'd0, w_in, im_in, in_valid};
      fwd_q.push_back(e);
      @(posedge clk);
      #1;
      e = fwd_q.pop_front();
      chk({e.tag, "0"}, {15'd0, w_out0, im_out0, ov0}, e.val);
      chk({e.tag, "1"}, {15'd0, w_out1, im_out1, ov1}, e.val);
      chk({e.tag, "2"}, {15'd0, w_out2, im_out2, ov2}, e.val);
   endtask

   task automatic smp(input int w, input int im);
      w_in     = w[7:0];
      im_in    = im[7:0];
      in_valid = 1'b1;
   endtask

   task automatic idle_in();
      in_valid = 1'b0;
      start    = 1'b0;
      w_in     = 8'h00;
      im_in    = 8'h00;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int k;
      k = 0;
      while (!done0 && k < budget) begin
         idle_in();
         tick();
         k++;
      end
      if (!done0)
         chk({tag, "_timeout"}, {31'd0, done0}, 32'd1);
   endtask

   initial begin
      rst = 1'b1; start = 1'b1; len = 10'd5; in_valid = 1'b1; w_in = 8'h33; im_in = 8'h44;
      tick();
      chk("rst_p", p0, 32'd0);
      chk("rst_busy", {31'd0, busy0}, 32'd0);
      chk("rst_done", {31'd0, done0}, 32'd0);
      chk("rst_ovf", {31'd0, ovf0}, 32'd0);
      rst = 1'b0;
      idle_in();

      // forwarding in IDLE, sample ignored
      w_in = 8'h5A; im_in = 8'hA5; in_valid = 1'b1;
      tick();
      chk("idle_p_hold", p0, 32'd0);

      // basic signed accumulation
      idle_in(); start = 1'b1; len = 10'd3;
      tick();
      chk("t1_busy", {31'd0, busy0}, 32'd1);
      start = 1'b0;
      smp(2, 3);   tick();
      smp(-4, 5);  tick();
      chk("t1_mid_p", p0, 32'hFFFF_FFF2);
      smp(7, -1);  push_res("t1_p", 32'hFFFF_FFEB); tick();
      chk("t1_done", {31'd0, done0}, 32'd1);
      chk("t1_busy_lo", {31'd0, busy0}, 32'd0);
      chk("t1_ovf", {31'd0, ovf0}, 32'd0);
      pop_res(p0);

      // forwarding in DONE, p holds
      w_in = 8'h5A; im_in = 8'hA5; in_valid = 1'b1;
      tick();
      chk("done_p_hold", p0, 32'hFFFF_FFEB);
      chk("done_persist", {31'd0, done0}, 32'd1);

      // overflow, 16-bit accumulator
      idle_in(); start = 1'b1; len = 10'd3;
      tick();
      start = 1'b0;
      smp(127, 127); tick();
      smp(127, 127); tick();
      chk("t3_no_ovf_yet", {31'd0, ovf1}, 32'd0);
      smp(127, 127);
      push_res("t3_p_sat", 32'h0000_7FFF);
      push_res("t3_p_wrap", 32'h0000_BD03);
      push_res("t3_p_wide", 32'd48387);
      tick();
      idle_in();
      wait_done("t3", 5);
      pop_res({16'd0, p1});
      pop_res({16'd0, p2});
      pop_res(p0);
      chk("t3_ovf_sat", {31'd0, ovf1}, 32'd1);
      chk("t3_ovf_wrap", {31'd0, ovf2}, 32'd1);
      chk("t3_ovf_wide", {31'd0, ovf0}, 32'd0);

      // bubbles; the start also clears the overflow state
      start = 1'b1; len = 10'd2;
      tick();
      chk("t3_clr_p1", {16'd0, p1}, 32'd0);
      chk("t3_clr_ovf1", {31'd0, ovf1}, 32'd0);
      chk("t3_clr_ovf2", {31'd0, ovf2}, 32'd0);
      start = 1'b0;
      smp(3, 4); tick();
      idle_in(); w_in = 8'h77; im_in = 8'h77; tick();
      tick();
      chk("t4_busy_bubble", {31'd0, busy0}, 32'd1);
      chk("t4_p_bubble", p0, 32'd12);
      smp(5, 6); push_res("t4_p", 32'd42); tick();
      chk("t4_done", {31'd0, done0}, 32'd1);
      pop_res(p0);

      // len == 0
      idle_in(); start = 1'b1; len = 10'd0;
      tick();
      chk("t5_len0_done", {31'd0, done0}, 32'd1);
      chk("t5_len0_p", p0, 32'd0);

      // sample alongside start is forwarded but not accumulated
      start = 1'b1; len = 10'd1; smp(9, 9);
      tick();
      chk("t5_start_smp_p", p0, 32'd0);
      chk("t5_start_smp_busy", {31'd0, busy0}, 32'd1);

      // restart mid-count
      start = 1'b1; len = 10'd3; in_valid = 1'b0;
      tick();
      start = 1'b0; smp(1, 1); tick();
      chk("t5_pre_restart", p0, 32'd1);
      start = 1'b1; len = 10'd2; smp(5, 5);
      tick();
      chk("t5_restart_p", p0, 32'd0);
      start = 1'b0;
      smp(2, 2); tick();
      chk("t5_restart_busy", {31'd0, busy0}, 32'd1);
      smp(3, 3); push_res("t5_restart", 32'd13); tick();
      idle_in();
      wait_done("t5", 5);
      pop_res(p0);

      // reset in the middle of an accumulation
      start = 1'b1; len = 10'd3;
      tick();
      start = 1'b0; smp(4, 4); tick();
      chk("t6_p_one", p0, 32'd16);
      rst = 1'b1; smp(4, 4);
      tick();
      rst = 1'b0;
      chk("t6_p", p0, 32'd0);
      chk("t6_busy", {31'd0, busy0}, 32'd0);
      chk("t6_done", {31'd0, done0}, 32'd0);
      chk("t6_ovf", {31'd0, ovf0}, 32'd0);
      smp(6, 6); tick();
      smp(7, 7); tick();
      chk("t6_ignored_p", p0, 32'd0);
      chk("t6_ignored_busy", {31'd0, busy0}, 32'd0);
      idle_in();
      tick();

      chk("res_queue_drained", res_q.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
